regfile_mp: RTL and testbench

Parametrised multi-port register file for the 16-bit processor datapath, successor to the single-port 8-bit file. It provides one synchronous write port, two asynchronous read ports (operands A and B), an optional hardwired zero register and optional write-to-read bypass. It also has a sequenced clear engine that zeroes the whole file one entry per cycle on request, without a global reset. It sits between the decoder/control unit (addresses, write enable) and the ALU/memory-address path (read data).

---
 rtl/regfile_mp.sv | 143 ++++++++++++++
 tb/tb_regfile_mp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with hardwired zero, write bypass and clear sweep
//
// Purpose: DEPTH x WIDTH register file for the processor datapath. One
// synchronous write port, two combinational read ports, an optional hardwired
// zero register, optional same-cycle write forwarding, and a clear engine that
// zeroes the file one entry per cycle without a global reset.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset (clears storage, FSM, counter)
//   we       - write enable
//   waddr    - write address
//   wdata    - write data
//   raddr_a  - read address, port A
//   rdata_a  - read data, port A (combinational)
//   raddr_b  - read address, port B
//   rdata_b  - read data, port B (combinational)
//   clr_req  - start a full clear sweep (sampled only while idle)
//   busy     - clear sweep in progress
//   wr_drop  - one-cycle registered pulse: a write was discarded during a sweep

module regfile_mp #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = 15,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic idle;
    logic wr_to_zero;
    logic wr_ok;
    logic fwd_ok;

    assign idle       = (state == IDLE);
    assign wr_to_zero = (ZERO_EN != 0) && (waddr == ZADDR);
    // Writes to the zero register vanish silently; they are not "dropped".
    assign wr_ok      = we && idle && !wr_to_zero;
    // Forwarding is only allowed when the write will actually land (idle).
    assign fwd_ok     = (BYPASS != 0) && we && idle;
    assign busy       = (state == SWEEP);

    // FSM state, sweep counter and drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wr_drop <= busy && we;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                // clr_req is deliberately not looked at here: no queuing.
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Storage: the sweep owns the write path while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port A: zero register, then forwarding, then storage.
    always_comb begin
        rdata_a = mem[raddr_a];
        if ((ZERO_EN != 0) && (raddr_a == ZADDR)) begin
            rdata_a = '0;
        end else if (fwd_ok && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rdata_b = mem[raddr_b];
        if ((ZERO_EN != 0) && (raddr_b == ZADDR)) begin
            rdata_b = '0;
        end else if (fwd_ok && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] raddr_a;
    logic [3:0] raddr_b;
    logic       clr_req;
    logic [7:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
    logic       busy, wr_drop, nb_busy, nb_wr_drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(nb_rdata_a), .raddr_b(raddr_b), .rdata_b(nb_rdata_b),
        .clr_req(clr_req), .busy(nb_busy), .wr_drop(nb_wr_drop)
    );

    typedef struct {
        logic       we;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i);
            raddr_b = 4'(15 - i);
            #1;
            chk({name, "_a"}, {8'h0, rdata_a}, 16'h0);
            chk({name, "_b"}, {8'h0, rdata_b}, 16'h0);
        end
    endtask

    initial begin
        int n;

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;

        // Write/read vectors: values are read in the same cycle as any write.
        vecs[0] = '{1'b1, 4'd15, 8'hAA, 4'd15, 4'd15, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 4'd0,  8'h00, 4'd15, 4'd0,  8'h00, 8'h00};
        vecs[2] = '{1'b1, 4'd1,  8'h5A, 4'd1,  4'd2,  8'h5A, 8'h00};
        vecs[3] = '{1'b1, 4'd2,  8'hC3, 4'd1,  4'd0,  8'h5A, 8'h00};
        vecs[4] = '{1'b0, 4'd0,  8'h00, 4'd1,  4'd2,  8'h5A, 8'hC3};
        vecs[5] = '{1'b0, 4'd0,  8'h00, 4'd1,  4'd1,  8'h5A, 8'h5A};
        vecs[6] = '{1'b1, 4'd3,  8'h77, 4'd3,  4'd3,  8'h77, 8'h77};

        step(); step();
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_drop", {15'h0, wr_drop}, 16'h0);
        rst = 1'b0;
        check_all_zero("reset_read");

        for (int i = 0; i < 7; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
            #1;
            chk($sformatf("vec%0d_a", i), {8'h0, rdata_a}, {8'h0, vecs[i].ea});
            chk($sformatf("vec%0d_b", i), {8'h0, rdata_b}, {8'h0, vecs[i].eb});
            step();
            chk($sformatf("vec%0d_drop", i), {15'h0, wr_drop}, 16'h0);
        end
        we = 1'b0;

        // Bypass off: old value in the write cycle, new value one cycle later.
        we = 1'b1; waddr = 4'd5; wdata = 8'h66; raddr_a = 4'd5;
        #1;
        chk("byp_on_same", {8'h0, rdata_a}, 16'h0066);
        chk("byp_off_same", {8'h0, nb_rdata_a}, 16'h0000);
        step();
        we = 1'b0;
        #1;
        chk("byp_off_next", {8'h0, nb_rdata_a}, 16'h0066);

        // Sweep 1: fill r0..r14, single clr_req pulse, watch r8 get cleared.
        for (int i = 0; i < 15; i++) write(4'(i), 8'(8'h10 + i));
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        raddr_a = 4'd8;
        n = 0;
        while (busy && n < 40) begin
            n++;
            #1;
            chk($sformatf("sweep1_r8_c%0d", n), {8'h0, rdata_a}, (n <= 9) ? 16'h0018 : 16'h0000);
            step();
        end
        chk("sweep1_len", 16'(n), 16'd16);
        check_all_zero("sweep1_after");

        // Sweep 2: dropped write on busy cycle 3, ignored clr_req on cycle 6.
        write(4'd4, 8'h20);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            we      = (n == 3);
            waddr   = 4'd4;
            wdata   = 8'h99;
            raddr_a = 4'd4;
            clr_req = (n == 6);
            #1;
            chk($sformatf("sweep2_drop_c%0d", n), {15'h0, wr_drop}, (n == 4) ? 16'h1 : 16'h0);
            if (n == 3) chk("sweep2_no_bypass", {8'h0, rdata_a}, 16'h0020);
            step();
        end
        we = 1'b0; clr_req = 1'b0;
        chk("sweep2_len", 16'(n), 16'd16);
        raddr_a = 4'd4;
        #1;
        chk("sweep2_r4", {8'h0, rdata_a}, 16'h0000);
        chk("sweep2_drop_end", {15'h0, wr_drop}, 16'h0);

        // First idle cycle after a sweep accepts a write.
        write(4'd7, 8'h3C);
        raddr_b = 4'd7;
        #1;
        chk("post_sweep_write", {8'h0, rdata_b}, 16'h003C);

        // Reset mid-sweep: drop a write on cycle 4 so wr_drop is high on cycle 5.
        write(4'd9, 8'h22);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n = 1;
        while (n < 5 && busy) begin
            we = (n == 4); waddr = 4'd6; wdata = 8'h55;
            step();
            n++;
        end
        we = 1'b0;
        chk("mid_busy_before", {15'h0, busy}, 16'h1);
        chk("mid_drop_before", {15'h0, wr_drop}, 16'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {15'h0, busy}, 16'h0);
        chk("mid_rst_drop", {15'h0, wr_drop}, 16'h0);
        check_all_zero("mid_rst_read");
        step();
        rst = 1'b0;
        write(4'd6, 8'h42);
        raddr_a = 4'd6;
        #1;
        chk("post_rst_write", {8'h0, rdata_a}, 16'h0042);
        chk("post_rst_busy", {15'h0, busy}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
